// File: rtl/mem_port_arbiter.sv
// Per-cycle arbiter between instruction fetch and data load/store for one single-ported memory.
// Define ARB_STATS_EN to add saturating conflict/misalign counters (stat_conflicts, stat_misal).
module mem_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int MAX_DBURST = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_rd,
  input  logic              ls_wr,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [2:0]        ls_func3,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_stall,
  output logic              ls_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_misal,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_func3,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_conflicts,
  output logic [15:0]       stat_misal
`endif
);

  localparam int CW = $clog2(MAX_DBURST + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DATA = 2'd2} st_t;

  st_t          st, st_nxt;
  logic [CW-1:0] dcnt;
  logic         dreq, data_grant, fetch_grant, misal, misal_grant, ld;

  assign dreq = ls_rd | ls_wr;
  assign ld   = ls_rd & ~ls_wr;

  always_comb begin
    misal = 1'b0;
    case (ls_func3)
      3'b001, 3'b101: misal = ls_addr[0];
      3'b010:         misal = |ls_addr[1:0];
      default:        misal = 1'b0;
    endcase
  end

  // Fetch wins only once data has held the port MAX_DBURST times in a row against it.
  assign data_grant  = ~rst & dreq & ~(if_req & (dcnt == CW'(MAX_DBURST)));
  assign fetch_grant = ~rst & if_req & ~data_grant;
  assign misal_grant = data_grant & misal;
  assign if_stall    = if_req & ~fetch_grant;
  assign ls_stall    = dreq & ~data_grant;

  always_comb begin
    mem_addr  = '0;
    mem_func3 = 3'b000;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    if (data_grant) begin
      mem_addr  = ls_addr;
      mem_func3 = ls_func3;
      mem_rd    = ld & ~misal;
      mem_wr    = ls_wr & ~misal;
      mem_wdata = ls_wdata;
    end else if (fetch_grant) begin
      mem_addr  = if_addr;
      mem_func3 = 3'b010;
    end
  end

  always_comb begin
    st_nxt = IDLE;
    case (st)
      IDLE: begin
        if (fetch_grant)     st_nxt = FETCH;
        else if (data_grant) st_nxt = DATA;
      end
      FETCH, DATA: begin
        if (!if_req && !dreq) st_nxt = IDLE;
        else if (fetch_grant) st_nxt = FETCH;
        else if (data_grant)  st_nxt = DATA;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      dcnt     <= '0;
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
      ls_misal <= 1'b0;
      if_rdata <= '0;
      ls_rdata <= '0;
    end else begin
      st       <= st_nxt;
      if_valid <= fetch_grant;
      ls_valid <= data_grant & (ld | misal);
      ls_misal <= misal_grant;
      if (fetch_grant) if_rdata <= mem_rdata;
      if (misal_grant)             ls_rdata <= '0;
      else if (data_grant && ld)   ls_rdata <= mem_rdata;
      if (fetch_grant || !if_req)  dcnt <= '0;
      else if (data_grant && dcnt != CW'(MAX_DBURST)) dcnt <= dcnt + 1'b1;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_conflicts <= '0;
      stat_misal     <= '0;
    end else begin
      if (if_req && dreq && stat_conflicts != 16'hFFFF) stat_conflicts <= stat_conflicts + 16'd1;
      if (misal_grant && stat_misal != 16'hFFFF)        stat_misal     <= stat_misal + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: reset, fetch, conflict, starvation, misalign, stats.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_stall, if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_rd, ls_wr;
  logic [ADDR_W-1:0] ls_addr;
  logic [2:0]        ls_func3;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_stall, ls_valid, ls_misal;
  logic [DATA_W-1:0] ls_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_func3;
  logic              mem_rd, mem_wr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef ARB_STATS_EN
  logic [15:0]       stat_conflicts, stat_misal;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DBURST(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall), .if_valid(if_valid), .if_rdata(if_rdata),
    .ls_rd(ls_rd), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_func3(ls_func3), .ls_wdata(ls_wdata),
    .ls_stall(ls_stall), .ls_valid(ls_valid), .ls_rdata(ls_rdata), .ls_misal(ls_misal),
    .mem_addr(mem_addr), .mem_func3(mem_func3), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .stat_conflicts(stat_conflicts), .stat_misal(stat_misal)
`endif
  );

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; ls_rd = 0; ls_wr = 0; ls_addr = '0;
    ls_func3 = 3'b010; ls_wdata = '0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    #1;
    checks++; if (if_valid !== 1'b0 || ls_valid !== 1'b0 || ls_misal !== 1'b0) begin errors++; $display("FAIL reset_valids: if_valid=%b ls_valid=%b ls_misal=%b expected 0", if_valid, ls_valid, ls_misal); end
    checks++; if (if_rdata !== '0 || ls_rdata !== '0) begin errors++; $display("FAIL reset_rdata: if_rdata=%h ls_rdata=%h expected 0", if_rdata, ls_rdata); end
    @(negedge clk); rst = 0;
    // Start a fetch, then assert reset in the middle of its cycle.
    @(negedge clk); if_req = 1; if_addr = 14'h010; mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (if_stall !== 1'b0 || mem_addr !== 14'h010) begin errors++; $display("FAIL reset_prefetch: if_stall=%b mem_addr=%h expected 0/010", if_stall, mem_addr); end
    #1 rst = 1;
    #1;
    checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== '0 || mem_func3 !== 3'b000) begin errors++; $display("FAIL reset_mem: rd=%b wr=%b addr=%h f3=%b expected all 0", mem_rd, mem_wr, mem_addr, mem_func3); end
    @(posedge clk); #1;
    checks++; if (if_valid !== 1'b0 || if_rdata !== '0) begin errors++; $display("FAIL reset_discard: if_valid=%b if_rdata=%h expected 0/0", if_valid, if_rdata); end
    @(negedge clk); rst = 0; idle_inputs();
    #1;
    checks++; if (int'(dut.st) != 0) begin errors++; $display("FAIL reset_st: st=%0d expected 0", int'(dut.st)); end
  endtask

  task automatic test_fetch();
    @(negedge clk); if_req = 1; if_addr = 14'h004; mem_rdata = 32'h00A00093;
    #1;
    checks++; if (if_stall !== 1'b0 || mem_addr !== 14'h004 || mem_func3 !== 3'b010 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL fetch_drive: stall=%b addr=%h f3=%b rd=%b wr=%b expected 0/004/010/0/0", if_stall, mem_addr, mem_func3, mem_rd, mem_wr); end
    @(posedge clk); #1;
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h00A00093) begin errors++; $display("FAIL fetch_data: if_valid=%b if_rdata=%h expected 1/00a00093", if_valid, if_rdata); end
    @(negedge clk); idle_inputs(); mem_rdata = 32'h11111111;
    @(posedge clk); #1;
    checks++; if (if_valid !== 1'b0 || if_rdata !== 32'h00A00093) begin errors++; $display("FAIL fetch_pulse: if_valid=%b if_rdata=%h expected 0/00a00093", if_valid, if_rdata); end
    checks++; if (int'(dut.st) != 0) begin errors++; $display("FAIL fetch_st_idle: st=%0d expected 0", int'(dut.st)); end
  endtask

  task automatic test_conflict();
    @(negedge clk); if_req = 1; if_addr = 14'h008; ls_rd = 1; ls_func3 = 3'b010; ls_addr = 14'h0080; mem_rdata = 32'h12345678;
    #1;
    checks++; if (if_stall !== 1'b1 || ls_stall !== 1'b0) begin errors++; $display("FAIL conflict_stall: if_stall=%b ls_stall=%b expected 1/0", if_stall, ls_stall); end
    checks++; if (mem_addr !== 14'h0080 || mem_rd !== 1'b1 || mem_wr !== 1'b0) begin errors++; $display("FAIL conflict_mem: addr=%h rd=%b wr=%b expected 0080/1/0", mem_addr, mem_rd, mem_wr); end
    @(posedge clk); #1;
    checks++; if (ls_valid !== 1'b1 || ls_rdata !== 32'h12345678 || ls_misal !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL conflict_result: ls_valid=%b ls_rdata=%h ls_misal=%b if_valid=%b expected 1/12345678/0/0", ls_valid, ls_rdata, ls_misal, if_valid); end
    @(negedge clk); idle_inputs();
    @(posedge clk); #1;
    checks++; if (ls_valid !== 1'b0 || ls_rdata !== 32'h12345678) begin errors++; $display("FAIL conflict_pulse: ls_valid=%b ls_rdata=%h expected 0/12345678", ls_valid, ls_rdata); end
  endtask

  task automatic test_starvation();
    logic [4:0] exp_if_stall = 5'b10111; // bit i = cycle i, only cycle 3 grants fetch
`ifdef ARB_STATS_EN
    logic [15:0] c0 = stat_conflicts;
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); if_req = 1; if_addr = 14'h020; ls_rd = 1; ls_func3 = 3'b010; ls_addr = 14'h0100;
      mem_rdata = 32'hA0000000 + i;
      #1;
      checks++; if (if_stall !== exp_if_stall[i] || ls_stall !== ~exp_if_stall[i]) begin errors++; $display("FAIL starve_cycle%0d: if_stall=%b ls_stall=%b expected %b/%b", i, if_stall, ls_stall, exp_if_stall[i], ~exp_if_stall[i]); end
      @(posedge clk); #1;
      checks++; if (if_valid !== ~exp_if_stall[i] || ls_valid !== exp_if_stall[i]) begin errors++; $display("FAIL starve_valid%0d: if_valid=%b ls_valid=%b expected %b/%b", i, if_valid, ls_valid, ~exp_if_stall[i], exp_if_stall[i]); end
    end
    checks++; if (if_rdata !== 32'hA0000003 || ls_rdata !== 32'hA0000004) begin errors++; $display("FAIL starve_data: if_rdata=%h ls_rdata=%h expected a0000003/a0000004", if_rdata, ls_rdata); end
`ifdef ARB_STATS_EN
    checks++; if (stat_conflicts - c0 !== 16'd5) begin errors++; $display("FAIL stat_conflicts: delta=%0d expected 5", stat_conflicts - c0); end
`endif
    @(negedge clk); idle_inputs();
    @(posedge clk);
  endtask

  task automatic test_misalign();
`ifdef ARB_STATS_EN
    logic [15:0] m0 = stat_misal;
`endif
    @(negedge clk); ls_wr = 1; ls_func3 = 3'b010; ls_addr = 14'h0082; ls_wdata = 32'hCAFEF00D; mem_rdata = 32'h55555555;
    #1;
    checks++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0 || ls_stall !== 1'b0) begin errors++; $display("FAIL misal_store_drive: wr=%b rd=%b ls_stall=%b expected 0/0/0", mem_wr, mem_rd, ls_stall); end
    @(posedge clk); #1;
    checks++; if (ls_valid !== 1'b1 || ls_misal !== 1'b1 || ls_rdata !== '0) begin errors++; $display("FAIL misal_store_result: ls_valid=%b ls_misal=%b ls_rdata=%h expected 1/1/0", ls_valid, ls_misal, ls_rdata); end
`ifdef ARB_STATS_EN
    checks++; if (stat_misal - m0 !== 16'd1) begin errors++; $display("FAIL stat_misal: delta=%0d expected 1", stat_misal - m0); end
`endif
    // Aligned store: real write, no valid pulse.
    @(negedge clk); ls_wr = 1; ls_func3 = 3'b010; ls_addr = 14'h0084;
    #1;
    checks++; if (mem_wr !== 1'b1 || mem_wdata !== 32'hCAFEF00D || mem_addr !== 14'h0084) begin errors++; $display("FAIL store_drive: wr=%b wdata=%h addr=%h expected 1/cafef00d/0084", mem_wr, mem_wdata, mem_addr); end
    @(posedge clk); #1;
    checks++; if (ls_valid !== 1'b0 || ls_misal !== 1'b0) begin errors++; $display("FAIL store_novalid: ls_valid=%b ls_misal=%b expected 0/0", ls_valid, ls_misal); end
    // Load and store together: the store wins.
    @(negedge clk); ls_rd = 1; ls_wr = 1; ls_func3 = 3'b000; ls_addr = 14'h0003;
    #1;
    checks++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_func3 !== 3'b000) begin errors++; $display("FAIL rdwr_priority: wr=%b rd=%b f3=%b expected 1/0/000", mem_wr, mem_rd, mem_func3); end
    // Halfword load on odd address is misaligned; HU on even is fine.
    @(negedge clk); ls_rd = 1; ls_wr = 0; ls_func3 = 3'b001; ls_addr = 14'h0081;
    #1;
    checks++; if (mem_rd !== 1'b0 || mem_addr !== 14'h0081) begin errors++; $display("FAIL misal_half_drive: rd=%b addr=%h expected 0/0081", mem_rd, mem_addr); end
    @(posedge clk); #1;
    checks++; if (ls_valid !== 1'b1 || ls_misal !== 1'b1 || ls_rdata !== '0) begin errors++; $display("FAIL misal_half_result: valid=%b misal=%b rdata=%h expected 1/1/0", ls_valid, ls_misal, ls_rdata); end
    @(negedge clk); ls_func3 = 3'b101; ls_addr = 14'h0086; mem_rdata = 32'h0000BEEF;
    #1;
    checks++; if (mem_rd !== 1'b1 || mem_func3 !== 3'b101) begin errors++; $display("FAIL hu_drive: rd=%b f3=%b expected 1/101", mem_rd, mem_func3); end
    @(posedge clk); #1;
    checks++; if (ls_valid !== 1'b1 || ls_misal !== 1'b0 || ls_rdata !== 32'h0000BEEF) begin errors++; $display("FAIL hu_result: valid=%b misal=%b rdata=%h expected 1/0/0000beef", ls_valid, ls_misal, ls_rdata); end
    @(negedge clk); idle_inputs();
    #1;
    checks++; if (mem_addr !== '0 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || mem_wdata !== '0 || if_stall !== 1'b0 || ls_stall !== 1'b0) begin errors++; $display("FAIL idle_mem: addr=%h rd=%b wr=%b wdata=%h stalls=%b%b expected all 0", mem_addr, mem_rd, mem_wr, mem_wdata, if_stall, ls_stall); end
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_conflict();
    test_starvation();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish within 20000 time units");
    $fatal(1);
  end
endmodule
